nibble_add_seq: RTL
===================

# nibble_add_seq

Multi-cycle sequencer that adds two wide operands by time-sharing one instance of the team's 4-bit ripple adder `fulladd4`, one nibble per clock, LSB nibble first. The carry is held in a register between nibbles. It sits between the Basys3 switch/button input logic and the seven-segment/LED display path. It replaces a wide combinational adder with a start/busy/done handshake.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width is W = 4*NIBBLES bits. Legal range is 2..8.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a new addition. Sampled only when `busy`=0.
- `a`  in  W  operand A. Captured on the accepted `start` edge.
- `b`  in  W  operand B. Captured on the accepted `start` edge.
- `c_in`  in  1  carry-in to nibble 0. Captured with the operands.
- `busy`  out  1  high while nibbles are being processed.
- `done`  out  1  one-cycle pulse when `sum`/`c_out` hold a new result.
- `sum`  out  W  registered result. Holds its value until the next completion.
- `c_out`  out  1  carry out of the top nibble. Registered; holds with `sum`.

## Operation
- Internal `fulladd4` instance uses port order (SUM, C_OUT, A, B, C_IN). Its A/B inputs are driven by nibble `idx` of the latched operands; its C_IN input is driven by the carry register.
- State machine:
  - IDLE. `busy`=0. On `start`=1, do all of the following and go to RUN:
    - latch `a`→opA, `b`→opB, `c_in`→carry
    - set idx=0
    - clear the internal result shadow register
  - RUN. `busy`=1. Each edge does all of the following:
    - write adder SUM into shadow nibble idx
    - set carry ← C_OUT
    - set idx ← idx+1
  - RUN exit. When idx = NIBBLES-1, that edge does all of the following and goes to IDLE:
    - copies the full shadow, including the nibble just computed, into `sum`
    - sets `c_out` ← C_OUT
    - sets `done` ← 1
- `done` is high for exactly one cycle. It is cleared on the next edge unconditionally.
- Arithmetic: the result is the plain unsigned value {c_out,sum} = a + b + c_in, modulo 2^(W+1). There is no saturation or overflow flag.
- `start` while `busy`=1 is ignored; there is no queueing. Changes to `a`/`b`/`c_in` during RUN have no effect.
- `idx` is a counter of width clog2(NIBBLES). It never wraps past NIBBLES-1.

## Timing
- Reset (`rst_n`=0 at an edge) sets:
  - state to IDLE
  - `busy`=0, `done`=0
  - `sum`=0, `c_out`=0
  - idx=0, carry=0, opA=opB=0, shadow=0
- Reset has priority over every other action at that edge.
- Reset mid-RUN aborts the operation. No `done` pulse is produced, and `sum`/`c_out` read 0 afterwards.
- Latency: `start` accepted at edge t0 → `busy`=1 from t0 through the cycle ending at edge tN, where N=NIBBLES. The following are updated at edge tN:
  - `sum` and `c_out`
  - `done`=1 for the cycle tN→tN+1
  - `busy`=0
- Throughput: the earliest next accept is edge tN+1, while `done` is high. That gives one result every N+1 cycles back-to-back.
- `start` high at the same edge as tN (`busy` still 1) is ignored.
- `sum`/`c_out` change only at a completion edge or at reset. They never change mid-operation.

## Test plan
- Reset, then `start` with a=0x0003, b=0x0004, c_in=0 (NIBBLES=4) → `busy` high for 4 cycles, `done` pulses once, `sum`=0x0007, `c_out`=0.
- a=0xFFFF, b=0x0001, c_in=0 → carry ripples through all nibbles, `sum`=0x0000, `c_out`=1. Then a=0x9999, b=0x9999, c_in=0 → `sum`=0x3332, `c_out`=1.
- a=0xAAAA, b=0x5555, c_in=1 → `sum`=0x0000, `c_out`=1. Checks that c_in feeds nibble 0 only.
- Hold `start`=1 continuously with operands changing every cycle → results are accepted exactly every 5 cycles. Each `sum` matches the operands present at its accept edge. Mid-run operand changes do not affect results.
- Start a=0x1234, b=0x1111, then drop `rst_n` for 1 cycle after 2 RUN cycles → no `done`; `busy`=0, `sum`=0, `c_out`=0. A new start of 0x1234+0x1111 then gives 0x2345.
- NIBBLES=2: a=0xFF, b=0x01, c_in=1 → `busy` high 2 cycles, `sum`=0x01, `c_out`=1.

Source files
------------

// File: rtl/nibble_add_seq.sv
// Sequential wide adder: one shared 4-bit ripple adder, one nibble per clock, LSB first.
// Carry is held in a register between nibbles; start/busy/done handshake.
`timescale 1ns/1ps

module fulladd4 (
   output logic [3:0] sum,
   output logic       c_out,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in
);

   logic ripple;

   always_comb begin
      ripple = c_in;
      sum    = '0;
      for (int i = 0; i < 4; i++) begin
         sum[i] = a[i] ^ b[i] ^ ripple;
         ripple = (a[i] & b[i]) | (ripple & (a[i] ^ b[i]));
      end
      c_out = ripple;
   end

endmodule

module nibble_add_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   c_in,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   c_out
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [W-1:0]     op_a;
   logic [W-1:0]     op_b;
   logic [W-1:0]     shadow;
   logic [W-1:0]     shadow_upd;
   logic [IDX_W-1:0] idx;
   logic             carry;

   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       nib_sum;
   logic             nib_cout;

   // Select the active nibble of each latched operand and merge the adder
   // result back into a copy of the shadow, so the exit edge can publish it.
   always_comb begin
      nib_a      = '0;
      nib_b      = '0;
      shadow_upd = shadow;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx == IDX_W'(i)) begin
            nib_a                 = op_a[4*i +: 4];
            nib_b                 = op_b[4*i +: 4];
            shadow_upd[4*i +: 4]  = nib_sum;
         end
      end
   end

   fulladd4 u_fa (
      .sum   (nib_sum),
      .c_out (nib_cout),
      .a     (nib_a),
      .b     (nib_b),
      .c_in  (carry)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         c_out  <= 1'b0;
         idx    <= '0;
         carry  <= 1'b0;
         op_a   <= '0;
         op_b   <= '0;
         shadow <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_a   <= a;
                  op_b   <= b;
                  carry  <= c_in;
                  idx    <= '0;
                  shadow <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               shadow <= shadow_upd;
               carry  <= nib_cout;
               // Last nibble: publish the whole result together with its carry.
               if (idx == LAST_IDX) begin
                  sum   <= shadow_upd;
                  c_out <= nib_cout;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
